// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared types and constants for the APB master bridge
package apb_master_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 32;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic                          write;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_DATA_WIDTH-1:0] wdata;
  } apb_req_t;

  // A disabled timeout (0) still needs a one-bit counter to keep widths legal.
  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// rtl/apb_wait_counter.sv - saturating ACCESS wait-state counter with terminal-count flag
module apb_wait_counter
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int           W       = cnt_width(TIMEOUT);
  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] TC_VAL  = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (TIMEOUT != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready request/response to two-phase APB requester
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA
);

  apb_state_e            state_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  psel_q;
  logic                  penable_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic accept;
  logic wait_tc;
  logic wait_clr;
  logic wait_en;

  // In RESP a new request may ride on the response handshake to save a cycle.
  assign req_ready = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  assign accept    = req_valid && req_ready;

  assign wait_clr = (state_q == SETUP);
  assign wait_en  = (state_q == ACCESS) && !PREADY && !wait_tc;

  apb_wait_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_wait (
    .clk_i(PCLK),
    .rst_i(PRESET),
    .clr_i(wait_clr),
    .en_i (wait_en),
    .tc_o (wait_tc)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // Address/data only move on accept, so an idle bus never toggles them.
      if (accept) begin
        paddr_q  <= req_addr;
        pwrite_q <= req_write;
        pwdata_q <= req_wdata;
      end
      case (state_q)
        IDLE: begin
          if (accept) begin
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end else if (wait_tc) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            if (accept) begin
              psel_q    <= 1'b1;
              penable_q <= 1'b0;
              state_q   <= SETUP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;
  import apb_master_pkg::*;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic        PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PREADY = 1'b0;
  logic [31:0] PRDATA = '0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int viol_cnt = 0;

  logic        prev_psel = 1'b1;
  logic [31:0] prev_paddr = '0;

  apb_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TO)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PADDR    (PADDR),
    .PSELx    (PSELx),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PREADY   (PREADY),
    .PRDATA   (PRDATA)
  );

  always #5 PCLK = ~PCLK;

  // Bus-protocol watcher: enable only after a select cycle, idle address frozen.
  always @(negedge PCLK) begin
    if (!PRESET) begin
      if (PENABLE && !PSELx) viol_cnt <= viol_cnt + 1;
      if (PENABLE && !prev_psel) viol_cnt <= viol_cnt + 1;
      if (!PSELx && !prev_psel && (PADDR !== prev_paddr)) viol_cnt <= viol_cnt + 1;
    end
    prev_psel  <= PSELx;
    prev_paddr <= PADDR;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One request through the bridge; expectations come from the transfer rules:
  // ACCESS lasts waits+1 cycles, or TO cycles if the slave never becomes ready.
  task automatic run_xfer(input apb_req_t r, input int waits, input logic [31:0] rd, input int bp);
    int          bound;
    int          acc;
    int          stable_err;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    exp_err   = (TO != 0) && (waits >= TO);
    exp_acc   = exp_err ? TO : waits + 1;
    exp_rdata = (exp_err || r.write) ? 32'h0 : rd;

    req_valid = 1'b1;
    req_write = r.write;
    req_addr  = r.addr;
    req_wdata = r.wdata;
    PREADY    = 1'b0;
    PRDATA    = rd;
    rsp_ready = 1'b0;
    #1;
    bound = 0;
    while (req_ready !== 1'b1 && bound < 20) begin
      @(negedge PCLK);
      #1;
      bound++;
    end
    total_cnt++;
    if (bound >= 20) $display("FAIL accept: req_ready=%b never high", req_ready);
    else pass_cnt++;

    @(negedge PCLK);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_write = ~r.write;
    total_cnt++;
    if (PSELx !== 1'b1 || PENABLE !== 1'b0 || PWRITE !== r.write || PADDR !== r.addr || PWDATA !== r.wdata)
      $display("FAIL setup: sel=%b en=%b wr=%b addr=%h wdata=%h expected 1 0 %b %h %h",
               PSELx, PENABLE, PWRITE, PADDR, PWDATA, r.write, r.addr, r.wdata);
    else pass_cnt++;

    acc = 0;
    stable_err = 0;
    bound = 0;
    while (rsp_valid !== 1'b1 && bound < 64) begin
      @(negedge PCLK);
      bound++;
      if (PSELx === 1'b1 && PENABLE === 1'b1) begin
        acc++;
        if (PADDR !== r.addr || PWRITE !== r.write || PWDATA !== r.wdata) stable_err++;
        PREADY = (acc > waits);
      end
    end
    PREADY = 1'b0;

    total_cnt++;
    if (bound !== exp_acc + 1) $display("FAIL latency: rsp after %0d cycles expected %0d", bound, exp_acc + 1);
    else pass_cnt++;
    total_cnt++;
    if (acc !== exp_acc) $display("FAIL access_cycles: got %0d expected %0d", acc, exp_acc);
    else pass_cnt++;
    total_cnt++;
    if (stable_err !== 0) $display("FAIL access_stable: %0d unstable cycles expected 0", stable_err);
    else pass_cnt++;
    total_cnt++;
    if (rsp_err !== exp_err) $display("FAIL rsp_err: got %b expected %b", rsp_err, exp_err);
    else pass_cnt++;
    total_cnt++;
    if (rsp_rdata !== exp_rdata) $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, exp_rdata);
    else pass_cnt++;
    total_cnt++;
    if (PSELx !== 1'b0 || PENABLE !== 1'b0) $display("FAIL resp_bus: sel=%b en=%b expected 0 0", PSELx, PENABLE);
    else pass_cnt++;

    for (int i = 0; i < bp; i++) begin
      if (i == 0) begin
        req_valid = 1'b1;
        req_addr  = $urandom;
      end
      #1;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rdata || rsp_err !== exp_err || req_ready !== 1'b0 || PSELx !== 1'b0)
        $display("FAIL backpressure: valid=%b rdata=%h err=%b req_ready=%b sel=%b expected 1 %h %b 0 0",
                 rsp_valid, rsp_rdata, rsp_err, req_ready, PSELx, exp_rdata, exp_err);
      else pass_cnt++;
      @(negedge PCLK);
    end

    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    total_cnt++;
    if (rsp_valid !== 1'b0 || PSELx !== 1'b0)
      $display("FAIL handshake: rsp_valid=%b sel=%b expected 0 0", rsp_valid, PSELx);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    total_cnt++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0 || PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0)
      $display("FAIL reset_outputs: sel=%b en=%b wr=%b rv=%b err=%b addr=%h wd=%h rd=%h expected all 0",
               PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, PWDATA, rsp_rdata);
    else pass_cnt++;
    total_cnt++;
    if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    else pass_cnt++;
    PRESET = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_write_zero_wait();
    run_xfer('{1'b1, 32'h10, 32'hDEADBEEF}, 0, 32'h1234_5678, 0);
  endtask

  task automatic test_read_wait();
    run_xfer('{1'b0, 32'h10, 32'h0}, 3, 32'hDEADBEEF, 0);
  endtask

  task automatic test_timeout();
    run_xfer('{1'b0, 32'h44, 32'h0}, 1000, 32'hCAFEF00D, 0);
  endtask

  task automatic test_backpressure();
    run_xfer('{1'b0, 32'h14, 32'h0}, 0, 32'hA5A5_1234, 5);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    int          acc_c [3];
    int          rsp_c [3];
    logic [31:0] set_a [3];
    int          na;
    int          nr;
    int          ns;
    int          rsp_sel_bad;
    logic        took;
    addrs[0] = 32'h0;
    addrs[1] = 32'h4;
    addrs[2] = 32'h8;
    na = 0;
    nr = 0;
    ns = 0;
    rsp_sel_bad = 0;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = addrs[0];
    req_wdata = $urandom;
    rsp_ready = 1'b1;
    PREADY    = 1'b1;
    for (int i = 0; i < 13; i++) begin
      #1;
      took = 1'b0;
      if (req_valid && req_ready === 1'b1 && na < 3) begin
        acc_c[na] = i;
        na++;
        took = 1'b1;
      end
      if (rsp_valid === 1'b1 && nr < 3) begin
        rsp_c[nr] = i;
        nr++;
        if (PSELx !== 1'b0) rsp_sel_bad++;
      end
      if (PSELx === 1'b1 && PENABLE === 1'b0 && ns < 3) begin
        set_a[ns] = PADDR;
        ns++;
      end
      @(negedge PCLK);
      if (took) begin
        if (na < 3) begin
          req_addr  = addrs[na];
          req_wdata = $urandom;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    total_cnt++;
    if (na !== 3 || nr !== 3 || ns !== 3) $display("FAIL b2b_counts: accepts=%0d rsps=%0d setups=%0d expected 3 3 3", na, nr, ns);
    else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      if (k < na) begin
        total_cnt++;
        if (acc_c[k] !== 3 * k) $display("FAIL b2b_accept_%0d: cycle %0d expected %0d", k, acc_c[k], 3 * k);
        else pass_cnt++;
      end
      if (k < nr) begin
        total_cnt++;
        if (rsp_c[k] !== 3 * k + 3) $display("FAIL b2b_rsp_%0d: cycle %0d expected %0d", k, rsp_c[k], 3 * k + 3);
        else pass_cnt++;
      end
      if (k < ns) begin
        total_cnt++;
        if (set_a[k] !== addrs[k]) $display("FAIL b2b_addr_%0d: got %h expected %h", k, set_a[k], addrs[k]);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (rsp_sel_bad !== 0) $display("FAIL b2b_psel_gap: %0d response cycles with PSELx high expected 0", rsp_sel_bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_access();
    int bad;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h30;
    PREADY    = 1'b0;
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    total_cnt++;
    if (PSELx !== 1'b1 || PENABLE !== 1'b1) $display("FAIL mid_access_entry: sel=%b en=%b expected 1 1", PSELx, PENABLE);
    else pass_cnt++;
    #1;
    PRESET = 1'b1;
    #1;
    total_cnt++;
    if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err} !== 5'b0 || PADDR !== 32'h0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1)
      $display("FAIL async_reset: sel=%b en=%b wr=%b rv=%b err=%b addr=%h rd=%h req_ready=%b expected 0s and req_ready 1",
               PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, PADDR, rsp_rdata, req_ready);
    else pass_cnt++;
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge PCLK);
      if (rsp_valid !== 1'b0 || PSELx !== 1'b0) bad++;
    end
    PREADY = 1'b0;
    total_cnt++;
    if (bad !== 0) $display("FAIL post_reset_quiet: %0d cycles with activity expected 0", bad);
    else pass_cnt++;
    run_xfer('{1'b0, 32'h20, 32'h0}, 1, 32'h0BAD_F00D, 0);
  endtask

  task automatic test_random();
    apb_req_t r;
    for (int n = 0; n < 16; n++) begin
      r.write = 1'($urandom_range(0, 1));
      r.addr  = $urandom & 32'hFFFF_FFFC;
      r.wdata = $urandom;
      run_xfer(r, $urandom_range(0, 5), $urandom, $urandom_range(0, 3));
    end
  endtask

  task automatic test_protocol();
    total_cnt++;
    if (viol_cnt !== 0) $display("FAIL protocol: %0d violations expected 0", viol_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester that drives the APB slave through APB_if.
- Converts a simple valid/ready request channel (write flag, address, write data) into a compliant two-phase APB transfer: SETUP, then ACCESS with wait states.
- Returns read data and a timeout error on a valid/ready response channel.
- Sits directly upstream of the APB slave; the slave bench can be driven from it.

Parameters:
- ADDR_WIDTH, 32, width of PADDR and req_addr
- DATA_WIDTH, 32, width of PWDATA/PRDATA, req_wdata and rsp_rdata
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
- PCLK  in  1  bus clock; all logic on posedge
- PRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid and req_ready are both high at posedge
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  transfer address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid and rsp_ready are both high at posedge
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors
- rsp_err  out  1  transfer aborted by timeout
- PADDR  out  ADDR_WIDTH  APB address
- PSELx  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_WIDTH  APB write data
- PREADY  in  1  slave ready
- PRDATA  in  DATA_WIDTH  slave read data

Behaviour:
- Reset (PRESET high, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except req_ready, which is 1.
  - Wait counter is cleared.
  - Any in-flight transfer is dropped with no response.
- All APB outputs and all rsp_* outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On accept: latch addr, write and wdata into PADDR, PWRITE and PWDATA; set PSELx = 1 and PENABLE = 0; go to SETUP.
- SETUP (exactly one cycle):
  - Set PENABLE = 1, clear the wait counter, go to ACCESS.
- ACCESS:
  - PSELx = 1 and PENABLE = 1.
  - PADDR, PWRITE and PWDATA are held stable.
  - PREADY high:
    - Capture PRDATA into rsp_rdata for a read; set rsp_rdata = 0 for a write.
    - Set rsp_err = 0 and rsp_valid = 1.
    - Drop PSELx and PENABLE; go to RESP.
  - PREADY low with TIMEOUT != 0 and wait counter == TIMEOUT-1:
    - Abort: rsp_err = 1, rsp_rdata = 0, rsp_valid = 1.
    - Drop PSELx and PENABLE; go to RESP.
  - Otherwise: increment the wait counter and stay in ACCESS.
  - Counter width is clog2(TIMEOUT+1); it never wraps.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held until the handshake.
  - req_ready = rsp_ready.
  - rsp handshake with no new request: rsp_valid = 0, go to IDLE.
  - rsp handshake with a new request accepted in the same cycle: latch the new request, go directly to SETUP.
- Latency: read data appears on rsp_rdata 3 posedges after request accept, given zero wait states. Each slave wait state adds one cycle.
- Back-to-back throughput: one transfer every 3 cycles when rsp_ready is held high.
- Idle bus:
  - PSELx = 0 and PENABLE = 0.
  - PADDR, PWRITE and PWDATA keep their last values (no toggling).
- req_ready is 0 in SETUP and ACCESS; req_* inputs are ignored there.
- PENABLE is never 1 while PSELx is 0.
- PENABLE is never 1 in the first cycle of PSELx.
- PRESET asserted mid-ACCESS: PSELx and PENABLE clear immediately (asynchronous); rsp_valid stays 0 after release.

Decomposition:
- Shared package apb_master_pkg contains:
  - state enum typedef apb_state_e {IDLE, SETUP, ACCESS, RESP}
  - default width constants
  - a packed request struct (write, addr, wdata)
- No sub-module is required.
- The wait/timeout counter may be factored out as apb_wait_counter (enable, clear, terminal-count output).

Test Plan:
1. Write, zero wait: req addr 0x10, wdata 0xDEADBEEF; slave PREADY held 1 -> one SETUP cycle (PSELx=1, PENABLE=0) then one ACCESS cycle (PENABLE=1); rsp_valid on the next posedge with rsp_err=0 and rsp_rdata=0.
2. Read, 3 wait states: read addr 0x10; PREADY low for 3 ACCESS cycles, then high with PRDATA=0xDEADBEEF -> ACCESS lasts 4 cycles; PADDR stable throughout; rsp_rdata=0xDEADBEEF.
3. Timeout: TIMEOUT=4, PREADY stuck 0 -> exactly 4 ACCESS cycles; PSELx drops; rsp_err=1 and rsp_rdata=0.
4. Back-to-back: rsp_ready=1 with req_valid held for writes to 0x0, 0x4, 0x8 -> PSELx falls for one cycle between transfers; three transfers take 9 cycles; addresses appear in order.
5. Response backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held, req_ready=0, no new SETUP; rsp_ready=1 -> handshake completes, return to IDLE.
6. Reset mid-ACCESS: assert PRESET during a wait state -> all outputs 0 and req_ready=1 immediately; after release no rsp_valid; a new read to 0x20 completes normally.
